// File: rtl/crc_pkg.sv
// Shared constants for the CRC memory-protection controllers.
// Holds the sequencer state encoding and default widths.
package crc_pkg;

    // 3-bit state codes, shared with the write-side controller
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RD    = ST_RD,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT,
        CHECK = ST_CHECK,
        DONE  = ST_DONE
    } crc_state_e;

    localparam int unsigned CRC_DATA_WIDTH    = 32;
    localparam int unsigned CRC_ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/crc_shift_counter.sv
// Clear/enable bit counter with terminal-count flag for CRC shifting.
// Ports: clk, rst (async active-low), clr_i, en_i, tc_o (count==DATA_WIDTH-1).
module crc_shift_counter
    import crc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CRC_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            // holds at LAST rather than wrapping
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/crc_check_controller.sv
// Read-side CRC check sequencer: read, load, shift DATA_WIDTH bits, compare.
// Ports: clk, rst (async active-low), read, write_mem_busy, crc_match in;
//   read_mem_en, load_en, shift_en, compare_en, read_busy, read_valid,
//   read_error out. Macro CRC_ERR_CNT_EN adds err_cnt_clr in, err_count out.
module crc_check_controller
    import crc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = CRC_DATA_WIDTH,
    parameter int unsigned ERR_CNT_WIDTH = CRC_ERR_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic                     write_mem_busy,
    input  logic                     crc_match,
`ifdef CRC_ERR_CNT_EN
    input  logic                     err_cnt_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
`endif
    output logic                     read_mem_en,
    output logic                     load_en,
    output logic                     shift_en,
    output logic                     compare_en,
    output logic                     read_busy,
    output logic                     read_valid,
    output logic                     read_error
);

    crc_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       read_error_q, read_error_d;
    logic       cnt_clr, cnt_en, cnt_tc;

    logic read_mem_en_q, load_en_q, shift_en_q, compare_en_q;
    logic read_busy_q, read_valid_q;

    crc_shift_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .tc_o (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        read_error_d = read_error_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // busy from the write side wins over a new request
                if ((read || pending_q) && !write_mem_busy) begin
                    state_d   = RD;
                    pending_d = 1'b0;
                end else if (read) begin
                    pending_d = 1'b1;
                end
            end
            RD: begin
                state_d = LOAD;
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                read_error_d = !crc_match;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // one-deep queue; requests while already pending are dropped
        if ((state_q != IDLE) && read) begin
            pending_d = 1'b1;
        end
    end

    // Strobes are flopped from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            read_error_q  <= 1'b0;
            read_mem_en_q <= 1'b0;
            load_en_q     <= 1'b0;
            shift_en_q    <= 1'b0;
            compare_en_q  <= 1'b0;
            read_busy_q   <= 1'b0;
            read_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            read_error_q  <= read_error_d;
            read_mem_en_q <= (state_d == RD);
            load_en_q     <= (state_d == LOAD);
            shift_en_q    <= (state_d == SHIFT);
            compare_en_q  <= (state_d == CHECK);
            read_busy_q   <= (state_d != IDLE) || pending_d;
            read_valid_q  <= (state_d == DONE);
        end
    end

    assign read_mem_en = read_mem_en_q;
    assign load_en     = load_en_q;
    assign shift_en    = shift_en_q;
    assign compare_en  = compare_en_q;
    assign read_busy   = read_busy_q;
    assign read_valid  = read_valid_q;
    assign read_error  = read_error_q;

`ifdef CRC_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if ((state_q == DONE) && read_error_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_check_controller.sv
// Directed self-checking bench for crc_check_controller (DATA_WIDTH=32).
// Optional error-counter steps build only with CRC_ERR_CNT_EN.
module tb_crc_check_controller;

    logic clk = 1'b0;
    logic rst;
    logic read, write_mem_busy, crc_match;
    logic read_mem_en, load_en, shift_en, compare_en;
    logic read_busy, read_valid, read_error;
`ifdef CRC_ERR_CNT_EN
    logic       err_cnt_clr;
    logic [1:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc_check_controller #(
        .DATA_WIDTH   (32),
        .ERR_CNT_WIDTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read          (read),
        .write_mem_busy(write_mem_busy),
        .crc_match     (crc_match),
`ifdef CRC_ERR_CNT_EN
        .err_cnt_clr   (err_cnt_clr),
        .err_count     (err_count),
`endif
        .read_mem_en   (read_mem_en),
        .load_en       (load_en),
        .shift_en      (shift_en),
        .compare_en    (compare_en),
        .read_busy     (read_busy),
        .read_valid    (read_valid),
        .read_error    (read_error)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {read_mem_en, load_en, shift_en, compare_en,
                read_busy, read_valid, read_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    // Called in the cycle where read_mem_en is due; ends in the DONE cycle
    task automatic expect_seq(input logic match, input logic exp_err,
                              input string tag);
        int n;
        crc_match = match;
        check({tag, "_rd"}, read_mem_en, 1'b1);
        check({tag, "_busy"}, read_busy, 1'b1);
        tick();
        check({tag, "_load"}, load_en, 1'b1);
        n = 0;
        tick();
        while (shift_en === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        check({tag, "_shifts"}, n, 32);
        check({tag, "_cmp"}, compare_en, 1'b1);
        tick();
        check({tag, "_valid"}, read_valid, 1'b1);
        check({tag, "_err"}, read_error, exp_err);
        check({tag, "_cmp_off"}, compare_en, 1'b0);
    endtask

    initial begin
        int nvalid, v1, v2, rd2, busy37;
        rst            = 1'b0;
        read           = 1'b0;
        write_mem_busy = 1'b0;
        crc_match      = 1'b0;
`ifdef CRC_ERR_CNT_EN
        err_cnt_clr    = 1'b0;
`endif
        #2;
        check("reset_outs", outs(), 7'd0);
        tick();
        tick();
        check("reset_outs_clk", outs(), 7'd0);
        rst = 1'b1;
        tick();
        check("idle_outs", outs(), 7'd0);

        // single matching check
        start_read();
        expect_seq(1'b1, 1'b0, "single");
        tick();
        check("single_after", outs(), 7'd0);

        // mismatch, error held while idle, then cleared by a good check
        start_read();
        expect_seq(1'b0, 1'b1, "mism");
        tick();
        tick();
        tick();
        check("mism_hold", outs(), 7'b0000001);
        start_read();
        expect_seq(1'b1, 1'b0, "clear");
        tick();

        // start blocked by write side for 10 cycles, read in cycle 2
        write_mem_busy = 1'b1;
        tick();
        tick();
        read = 1'b1;
        tick();
        read = 1'b0;
        check("blk_busy", read_busy, 1'b1);
        check("blk_norm", read_mem_en, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("blk_hold", {read_busy, read_mem_en}, 2'b10);
        end
        write_mem_busy = 1'b0;
        tick();
        expect_seq(1'b1, 1'b0, "blk");
        tick();
        check("blk_after", outs(), 7'd0);

        // back-to-back: reads at edges 0, 5, 10
        nvalid = 0;
        v1     = -1;
        v2     = -1;
        rd2    = -1;
        busy37 = -1;
        crc_match = 1'b1;
        for (int e = 0; e < 100; e++) begin
            read = (e == 0 || e == 5 || e == 10);
            tick();
            if (read_valid === 1'b1) begin
                nvalid++;
                if (nvalid == 1) v1 = e + 1;
                if (nvalid == 2) v2 = e + 1;
            end
            if (read_mem_en === 1'b1 && e > 0 && rd2 < 0) rd2 = e + 1;
            if (e + 1 == 37) busy37 = int'(read_busy);
        end
        read = 1'b0;
        check("b2b_nvalid", nvalid, 2);
        check("b2b_v1", v1, 36);
        check("b2b_rd2", rd2, 38);
        check("b2b_v2", v2, 73);
        check("b2b_gap_busy", busy37, 1);
        check("b2b_idle", outs(), 7'd0);

        // reset mid-SHIFT clears everything including read_error
        start_read();
        expect_seq(1'b0, 1'b1, "pre_rst");
        tick();
        start_read();
        for (int i = 0; i < 14; i++) tick();
        check("rst_in_shift", {shift_en, read_error}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", outs(), 7'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_held", outs(), 7'd0);
        end
        rst = 1'b1;
        tick();
        check("rst_release", outs(), 7'd0);
        start_read();
        expect_seq(1'b1, 1'b0, "post_rst");
        tick();

`ifdef CRC_ERR_CNT_EN
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        check("ecnt_clr0", err_count, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            start_read();
            expect_seq(1'b0, 1'b1, "ecnt");
            tick();
            check("ecnt_val", err_count, (k > 3) ? 3 : k);
        end
        start_read();
        expect_seq(1'b0, 1'b1, "ecnt6");
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        check("ecnt_clr_prio", err_count, 2'd0);
        tick();
        check("ecnt_stay0", err_count, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
